ctrl_fsm: RTL
=============

// Module: ctrl_fsm
// PURPOSE
//  Multi-cycle control unit: the consumer side of the fetch datapath. Latches the fetched instr word,
//  decodes the reduced RV32I subset, generates the immediate (IMMop) and branch select (PCsrc).
//  Drives the PC-register enable plus regfile/ALU/memory controls. One instruction in flight.
// PARAMETERS
//  W      32  data/instruction width
//  CNT_W  16  width of retired-instruction counter
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-low reset
//  instr      in   W      instruction word from instruction ROM (addressed by current PC)
//  eq         in   1      ALU compare result, 1 = rs1 == rs2
//  mem_ready  in   1      data memory done (read data valid / write accepted)
//  pc_en      out  1      PC register load enable, one-cycle pulse per instruction
//  PCsrc      out  1      1 = next PC is PC+IMMop, 0 = PC+4; meaningful only while pc_en=1
//  IMMop      out  W      sign-extended immediate of current instruction
//  RegWrite   out  1      regfile write enable
//  ALUsrc     out  1      1 = ALU operand B is IMMop, 0 = rs2
//  ALUctrl    out  3      000 add, 001 sub
//  MemRead    out  1      data memory read request
//  MemWrite   out  1      data memory write request
//  rs1/rs2/rd out  5 each register addresses from IR[19:15]/[24:20]/[11:7]
//  trap       out  1      sticky illegal-instruction flag
//  retired    out  CNT_W  count of completed instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (rst=0, any state, async): state=FETCH, IR=0, IMMop=0, retired=0, trap=0.
//   All strobes (pc_en,PCsrc,RegWrite,MemRead,MemWrite) and ALUsrc/ALUctrl are 0.
//  Supported (else illegal): ADD op 0110011 f3 000 f7 0000000; ADDI op 0010011 f3 000;
//   LW op 0000011 f3 010; SW op 0100011 f3 010; BEQ op 1100011 f3 000; BNE op 1100011 f3 001.
//  Immediates, registered in DECODE:
//   I {20{i[31]},i[31:20]}; S {20{i[31]},i[31:25],i[11:7]}.
//   B {19{i[31]},i[31],i[7],i[30:25],i[11:8],1'b0}. ADD: IMMop=0.
//  States:
//   FETCH : IR<=instr at clock edge; ->DECODE.
//   DECODE: register IMMop; illegal ->TRAP; else ->EXEC.
//   EXEC  : ALUctrl=sub for BEQ/BNE, else add; ALUsrc=1 for ADDI/LW/SW.
//           Branch: pc_en=1, PCsrc=(BEQ&eq)|(BNE&~eq), retired++, ->FETCH.
//           ADD/ADDI ->WB. LW/SW ->MEM.
//   MEM   : MemRead (LW) or MemWrite (SW) held high until mem_ready=1 (may be same cycle).
//           On ready: LW ->WB; SW pc_en=1, retired++, ->FETCH.
//   WB    : RegWrite=1, pc_en=1, PCsrc=0, retired++, ->FETCH.
//   TRAP  : trap=1, all strobes 0, stays until reset; pc_en never pulses.
//  ALUsrc/ALUctrl held stable EXEC..WB for the instruction.
//  Latency, fetch to pc_en, with mem_ready immediate: branch 3, ADD/ADDI 4, SW 4, LW 5 cycles;
//   each mem_ready-low cycle adds 1.
//  PCsrc=0 whenever pc_en=0. rs1/rs2/rd are combinational from IR, stable DECODE..end of instruction.
//  eq sampled only in EXEC of a branch. mem_ready ignored outside MEM.
//  RegWrite to rd=x0 still asserted; regfile discards.
//  retired wraps to 0 past all-ones, no flag.
// TESTING
//  1 rst low during MEM of LW with MemRead=1 -> MemRead=0 immediately; after release FETCH, retired=0.
//  2 ADDI x1,x0,5 (0x00500093) -> IMMop=0x00000005, ALUsrc=1, rd=1; RegWrite+pc_en in cycle 4, retired=1.
//  3 BNE x1,x2,-8 (0xFE209CE3), eq=0 -> IMMop=0xFFFFFFF8, ALUctrl=001, cycle 3 pc_en=1 PCsrc=1.
//    Same with eq=1 -> PCsrc=0.
//  4 LW x3,12(x1) (0x00C0A183), mem_ready low 3 cycles -> MemRead high 4 cycles.
//    Then WB: RegWrite=1, rd=3; pc_en at cycle 8.
//  5 instr=0xFFFFFFFF -> trap=1 from cycle 3 onward, pc_en stays 0 for 20 cycles; rst clears trap.
//  6 CNT_W=2, five ADD x0,x0,x0 (0x00000033) -> retired 1,2,3,0,1.

Source files
------------

// File: rtl/ctrl_fsm.sv
// Multi-cycle control unit for the reduced RV32I fetch datapath: latches the fetched word,
// decodes it, builds the immediate and sequences regfile/ALU/memory strobes, one instruction at a time.
module ctrl_fsm #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     instr,
  input  logic             eq,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             PCsrc,
  output logic [W-1:0]     IMMop,
  output logic             RegWrite,
  output logic             ALUsrc,
  output logic [2:0]       ALUctrl,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  typedef enum logic [2:0] {OP_ADD, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ILL} op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  state_t       state;
  op_t          op_q;
  op_t          dec_op;
  logic [W-1:0] ir;
  logic [W-1:0] dec_imm;
  logic         is_br;
  logic         br_take;

  function automatic op_t decode(input logic [31:0] i);
    op_t r;
    r = OP_ILL;
    case (i[6:0])
      7'b0110011: if (i[14:12] == 3'b000 && i[31:25] == 7'b0000000) r = OP_ADD;
      7'b0010011: if (i[14:12] == 3'b000) r = OP_ADDI;
      7'b0000011: if (i[14:12] == 3'b010) r = OP_LW;
      7'b0100011: if (i[14:12] == 3'b010) r = OP_SW;
      7'b1100011: begin
        if (i[14:12] == 3'b000)      r = OP_BEQ;
        else if (i[14:12] == 3'b001) r = OP_BNE;
      end
      default: r = OP_ILL;
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] imm_gen(input op_t op, input logic [31:0] i);
    logic [W-1:0] r;
    r = '0;
    case (op)
      OP_ADDI, OP_LW: r = {{(W-12){i[31]}}, i[31:20]};
      OP_SW:          r = {{(W-12){i[31]}}, i[31:25], i[11:7]};
      OP_BEQ, OP_BNE: r = {{(W-13){i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default:        r = '0;
    endcase
    return r;
  endfunction

  assign dec_op  = decode(ir[31:0]);
  assign dec_imm = imm_gen(dec_op, ir[31:0]);

  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign rd  = ir[11:7];

  // eq and mem_ready act within the same cycle, so the PC strobes are decoded from state
  assign is_br   = (op_q == OP_BEQ) || (op_q == OP_BNE);
  assign br_take = ((op_q == OP_BEQ) && eq) || ((op_q == OP_BNE) && !eq);
  assign pc_en   = ((state == EXEC) && is_br) ||
                   ((state == MEM) && (op_q == OP_SW) && mem_ready) ||
                   (state == WB);
  assign PCsrc   = (state == EXEC) && is_br && br_take;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FETCH;
      op_q     <= OP_ADD;
      ir       <= '0;
      IMMop    <= '0;
      RegWrite <= 1'b0;
      ALUsrc   <= 1'b0;
      ALUctrl  <= ALU_ADD;
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
      trap     <= 1'b0;
      retired  <= '0;
    end else begin
      if (pc_en) retired <= retired + 1'b1;
      case (state)
        FETCH: begin
          ir    <= instr;
          state <= DECODE;
        end
        DECODE: begin
          IMMop <= dec_imm;
          op_q  <= dec_op;
          if (dec_op == OP_ILL) begin
            trap  <= 1'b1;
            state <= TRAP;
          end else begin
            ALUsrc  <= (dec_op == OP_ADDI) || (dec_op == OP_LW) || (dec_op == OP_SW);
            ALUctrl <= ((dec_op == OP_BEQ) || (dec_op == OP_BNE)) ? ALU_SUB : ALU_ADD;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (is_br) begin
            ALUsrc  <= 1'b0;
            ALUctrl <= ALU_ADD;
            state   <= FETCH;
          end else if ((op_q == OP_ADD) || (op_q == OP_ADDI)) begin
            RegWrite <= 1'b1;
            state    <= WB;
          end else begin
            MemRead  <= (op_q == OP_LW);
            MemWrite <= (op_q == OP_SW);
            state    <= MEM;
          end
        end
        MEM: begin
          if (mem_ready) begin
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            if (op_q == OP_LW) begin
              RegWrite <= 1'b1;
              state    <= WB;
            end else begin
              ALUsrc  <= 1'b0;
              ALUctrl <= ALU_ADD;
              state   <= FETCH;
            end
          end
        end
        WB: begin
          RegWrite <= 1'b0;
          ALUsrc   <= 1'b0;
          ALUctrl  <= ALU_ADD;
          state    <= FETCH;
        end
        TRAP: state <= TRAP;
        default: state <= FETCH;
      endcase
    end
  end

endmodule
